// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs with trap entry, mret and privilege mode.
// Optional 64-bit mcycle/minstret counters when CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter logic [31:0] HART_ID   = 32'h0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
  parameter logic [31:0] RESET_VEC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_unimpl,
  input  logic        instret,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        mret,
  output logic [1:0]  current_mode,
  output logic [31:0] trap_vector,
  output logic [31:0] epc,
  output logic        mie_global
);
  logic        st_mie, st_mpie;
  logic [1:0]  st_mpp, mode;
  logic [31:0] mie_r, mscratch, mcause, mtval, mstatus;
  logic [29:0] mtvec_hi, mepc_hi;
  logic        wr, unused_ok;
  // trap and mret each swallow a coincident CSR write
  assign wr = csr_we && !trap_valid && !mret;
  assign mstatus = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign current_mode = mode;
  assign trap_vector = {mtvec_hi, 2'b00};
  assign epc = {mepc_hi, 2'b00};
  assign mie_global = st_mie;
  assign unused_ok = ^{trap_pc[1:0], instret};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      st_mpp   <= 2'b11;
      mode     <= 2'b11;
      mie_r    <= '0;
      mtvec_hi <= RESET_VEC[31:2];
      mscratch <= '0;
      mepc_hi  <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_valid) begin
      mepc_hi <= trap_pc[31:2];
      mcause  <= trap_cause;
      mtval   <= trap_val;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
      st_mpp  <= mode;
      mode    <= 2'b11;
    end else if (mret) begin
      mode    <= st_mpp;
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
      st_mpp  <= 2'b00;
    end else if (wr) begin
      case (csr_addr)
        12'h300: begin
          st_mie  <= csr_wdata[3];
          st_mpie <= csr_wdata[7];
          st_mpp  <= (csr_wdata[12:11] == 2'b11) ? 2'b11 : 2'b00;
        end
        12'h304: mie_r    <= csr_wdata;
        12'h305: mtvec_hi <= csr_wdata[31:2];
        12'h340: mscratch <= csr_wdata;
        12'h341: mepc_hi  <= csr_wdata[31:2];
        12'h342: mcause   <= csr_wdata;
        12'h343: mtval    <= csr_wdata;
        default: ;
      endcase
    end
  end
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
  // a write to either half replaces that cycle's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= (wr && csr_addr == 12'hB00) ? {mcycle[63:32], csr_wdata} :
                  (wr && csr_addr == 12'hB80) ? {csr_wdata, mcycle[31:0]} : mcycle + 64'd1;
      minstret <= (wr && csr_addr == 12'hB02) ? {minstret[63:32], csr_wdata} :
                  (wr && csr_addr == 12'hB82) ? {csr_wdata, minstret[31:0]} :
                  instret ? minstret + 64'd1 : minstret;
    end
  end
`endif
  always_comb begin
    csr_rdata  = '0;
    csr_unimpl = 1'b0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus;
      12'h301: csr_rdata = MISA_VAL;
      12'h304: csr_rdata = mie_r;
      12'h305: csr_rdata = {mtvec_hi, 2'b00};
      12'h340: csr_rdata = mscratch;
      12'h341: csr_rdata = {mepc_hi, 2'b00};
      12'h342: csr_rdata = mcause;
      12'h343: csr_rdata = mtval;
      12'hF14: csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: csr_rdata = mcycle[31:0];
      12'hB80, 12'hC80: csr_rdata = mcycle[63:32];
      12'hB02, 12'hC02: csr_rdata = minstret[31:0];
      12'hB82, 12'hC82: csr_rdata = minstret[63:32];
`endif
      default: csr_unimpl = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed scoreboard bench for csr_file.
module tb_csr_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, trap_val, trap_vector, epc;
  logic        csr_unimpl, instret, trap_valid, mret, mie_global;
  logic [1:0]  current_mode;
  logic        chk = 1'b0;
  string       nq[$];
  logic [31:0] eq[$];
  int          sq[$];
  int          vectors = 0;
  int          fails = 0;
  string       m_name;
  logic [31:0] m_exp, m_act;
  int          m_sel;

  csr_file #(.HART_ID(32'd3), .MISA_VAL(32'h4000_0100), .RESET_VEC(32'h8000_0003)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_unimpl(csr_unimpl), .instret(instret),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .mret(mret), .current_mode(current_mode), .trap_vector(trap_vector), .epc(epc),
    .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  // sel: 0 rdata, 1 unimpl, 2 mode, 3 mie_global, 4 epc, 5 trap_vector
  always @(negedge clk) begin
    if (chk) begin
      if (eq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        m_name = nq.pop_front();
        m_exp  = eq.pop_front();
        m_sel  = sq.pop_front();
        m_act  = (m_sel == 0) ? csr_rdata : (m_sel == 1) ? {31'b0, csr_unimpl} :
                 (m_sel == 2) ? {30'b0, current_mode} : (m_sel == 3) ? {31'b0, mie_global} :
                 (m_sel == 4) ? epc : trap_vector;
        vectors++;
        if (m_act !== m_exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic check(input logic [11:0] a, input int s, input logic [31:0] e, input string n);
    csr_addr = a;
    nq.push_back(n);
    eq.push_back(e);
    sq.push_back(s);
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1;
    csr_addr = a;
    csr_wdata = d;
    @(posedge clk);
    #1 csr_we = 1'b0;
  endtask

  task automatic pulse_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] val);
    trap_valid = 1'b1;
    trap_pc = pc;
    trap_cause = cause;
    trap_val = val;
    @(posedge clk);
    #1 trap_valid = 1'b0;
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    @(posedge clk);
    #1 mret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    csr_addr = '0; csr_we = 1'b0; csr_wdata = '0; instret = 1'b0;
    trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0; mret = 1'b0;
    @(posedge clk);
    #1;
    check(12'h305, 0, 32'h8000_0000, "rst_mtvec");
    check(12'h300, 0, 32'h0000_1800, "rst_mstatus");
    check(12'h300, 2, 32'd3, "rst_mode");
    check(12'h300, 5, 32'h8000_0000, "rst_trap_vector");
    rst_n = 1'b1;
    check(12'h301, 0, 32'h4000_0100, "misa");
    check(12'hF14, 0, 32'd3, "mhartid");
    check(12'hF14, 1, 32'd0, "mhartid_impl");
    wr(12'h300, 32'hFFFF_FFFF);
    check(12'h300, 0, 32'h0000_1888, "mstatus_warl");
    check(12'h300, 3, 32'd1, "mie_global_set");
    wr(12'h341, 32'h1234_5677);
    check(12'h341, 0, 32'h1234_5674, "mepc_warl");
    check(12'h341, 4, 32'h1234_5674, "epc_out");
    wr(12'h305, 32'h0000_0203);
    check(12'h305, 0, 32'h0000_0200, "mtvec_warl");
    check(12'h305, 5, 32'h0000_0200, "trap_vector_out");
    wr(12'h301, 32'h0);
    check(12'h301, 0, 32'h4000_0100, "misa_readonly");
    wr(12'h304, 32'hDEAD_BEEF);
    check(12'h304, 0, 32'hDEAD_BEEF, "mie_reg");
    pulse_trap(32'h100, 32'd2, 32'h55);
    check(12'h341, 0, 32'h100, "trap_mepc");
    check(12'h342, 0, 32'd2, "trap_mcause");
    check(12'h343, 0, 32'h55, "trap_mtval");
    check(12'h300, 0, 32'h0000_1880, "trap_mstatus");
    check(12'h300, 3, 32'd0, "trap_mie_clear");
    check(12'h300, 2, 32'd3, "trap_mode");
    pulse_mret();
    check(12'h300, 0, 32'h0000_0088, "mret_mstatus");
    check(12'h300, 2, 32'd3, "mret_mode_m");
    check(12'h300, 3, 32'd1, "mret_mie");
    pulse_mret();
    check(12'h300, 2, 32'd0, "mret_to_user");
    pulse_trap(32'h207, 32'd8, 32'h0);
    check(12'h300, 0, 32'h0000_0080, "trap_from_user_mstatus");
    check(12'h341, 0, 32'h204, "trap_pc_mask");
    check(12'h300, 2, 32'd3, "trap_from_user_mode");
    wr(12'h340, 32'h5555);
    csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hAAAA;
    pulse_trap(32'h300, 32'd7, 32'h0);
    csr_we = 1'b0;
    check(12'h340, 0, 32'h5555, "trap_drops_write");
    check(12'h342, 0, 32'd7, "trap_over_write_cause");
    csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hAAAA;
    pulse_mret();
    csr_we = 1'b0;
    check(12'h340, 0, 32'h5555, "mret_drops_write");
    mret = 1'b1;
    pulse_trap(32'h400, 32'd9, 32'h0);
    mret = 1'b0;
    check(12'h300, 0, 32'h0000_1800, "trap_over_mret");
    check(12'h342, 0, 32'd9, "trap_over_mret_cause");
    wr(12'h300, 32'h0000_0800);
    check(12'h300, 0, 32'h0, "mpp_illegal_to_user");
    csr_we = 1'b1; csr_wdata = 32'h1111;
    check(12'h340, 0, 32'h5555, "rw_same_cycle_old");
    csr_we = 1'b0;
    check(12'h340, 0, 32'h1111, "rw_next_cycle_new");
    check(12'h7C0, 0, 32'h0, "unimpl_rdata");
    check(12'h7C0, 1, 32'd1, "unimpl_flag");
    wr(12'h7C0, 32'hFFFF_FFFF);
    check(12'h340, 0, 32'h1111, "unimpl_write_ignored");
    check(12'h340, 1, 32'd0, "impl_flag");
`ifdef CSR_COUNTERS_EN
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check(12'hB00, 0, 32'd1, "mcycle_lo_wrap");
    check(12'hB80, 0, 32'd1, "mcycle_hi_carry");
    check(12'hC80, 0, 32'd1, "cycle_shadow_hi");
    instret = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    instret = 1'b0;
    check(12'hB02, 0, 32'd5, "minstret_lo");
    check(12'hB82, 0, 32'd0, "minstret_hi");
    wr(12'hC02, 32'h0);
    check(12'hC02, 0, 32'd5, "instret_shadow_ro");
`else
    check(12'hB00, 1, 32'd1, "mcycle_absent_flag");
    check(12'hB00, 0, 32'd0, "mcycle_absent_rdata");
`endif
    rst_n = 1'b0;
    check(12'h340, 0, 32'h0, "async_rst_mscratch");
    check(12'h300, 0, 32'h0000_1800, "async_rst_mstatus");
    if (eq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", eq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode CSR register file for the core. It sits directly downstream of the CSR read-modify-write unit: its `csr_rdata` feeds that unit's `csr_reg` input, and it commits that unit's `csr_new` result when the instruction retires legally. It also holds trap state, performs trap entry and `mret` return, tracks the current privilege mode, and runs the cycle and instret counters.

## Interface
- `HART_ID`, default 0: value returned by `mhartid` (0xF14).
- `MISA_VAL`, default 32'h4000_0100 (RV32I): value returned by `misa` (0x301).
- `RESET_VEC`, default 32'h0000_0000: reset value of `mtvec`.

Ports (clock and reset first):
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `csr_addr`  in  12  CSR address for the read and for the write.
- `csr_we`  in  1  commit strobe; the decode/commit stage drives it as system && !illegal_csr && retiring.
- `csr_wdata`  in  32  new value, i.e. `csr_new` from the RMW unit.
- `csr_rdata`  out  32  combinational read of `csr_addr`.
- `csr_unimpl`  out  1  combinational; 1 when `csr_addr` is not implemented.
- `instret`  in  1  one-cycle pulse per retired instruction.
- `trap_valid`  in  1  trap entry this cycle.
- `trap_cause`  in  32  written to `mcause`.
- `trap_pc`  in  32  written to `mepc`.
- `trap_val`  in  32  written to `mtval`.
- `mret`  in  1  `mret` is retiring this cycle.
- `current_mode`  out  2  privilege mode: 2'b11 = M, 2'b00 = U.
- `trap_vector`  out  32  {mtvec[31:2], 2'b00}.
- `epc`  out  32  current `mepc`.
- `mie_global`  out  1  mstatus.MIE.

## Operation
- Implemented CSRs and their reset values:
  - `mstatus` 0x300: only MIE[3], MPIE[7] and MPP[12:11] are storage; every other bit reads 0. Reset: 0, MPP = 2'b11.
  - `misa` 0x301 and `mhartid` 0xF14: read-only; writes are ignored.
  - `mie` 0x304: full 32-bit register. Reset 0.
  - `mtvec` 0x305: bits [1:0] are hardwired to 0 (direct mode only). Reset {RESET_VEC[31:2], 2'b00}.
  - `mscratch` 0x340: full 32-bit register. Reset 0.
  - `mepc` 0x341: bits [1:0] are hardwired to 0. Reset 0.
  - `mcause` 0x342 and `mtval` 0x343: full 32-bit registers. Reset 0.
- Any other address: `csr_rdata` = 0, `csr_unimpl` = 1, writes are ignored.
- WARL masks are applied on write. A read returns the masked, stored value.
- Trap entry (`trap_valid` = 1):
  - `mepc` <= {trap_pc[31:2], 2'b00}; `mcause` <= trap_cause; `mtval` <= trap_val.
  - MPIE <= MIE; MIE <= 0; MPP <= `current_mode`; mode <= 2'b11.
- `mret`:
  - mode <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= 2'b00.
- Priority when events coincide in one cycle: `trap_valid` > `mret` > `csr_we`. A lower-priority event is dropped entirely, including its CSR write.
- Mode reset value is 2'b11. The mode register holds only 2'b11 or 2'b00; an MPP write of 2'b01 or 2'b10 is stored as 2'b00.

## Timing
- Reads are combinational in the same cycle. Writes, trap and `mret` effects are visible on `csr_rdata` and the outputs from the cycle after the edge.
- Read and write of the same address in one cycle: `csr_rdata` returns the old value. There is no bypass.
- Every output is driven from reset state while `rst_n` is low; asserting reset mid-operation returns all registers to their reset values immediately.
- `trap_vector` and `epc` are registered-state outputs with zero added latency.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - 64-bit `mcycle` (0xB00 low / 0xB80 high) increments every cycle.
  - 64-bit `minstret` (0xB02 / 0xB82) increments when `instret` = 1.
  - User read-only shadows: `cycle` 0xC00/0xC80 and `instret` 0xC02/0xC82. Writes to the shadows are ignored.
  - Both counters reset to 0 and wrap from 2^64−1 to 0.
  - A CSR write to a counter half in the same cycle as an increment: the written half takes `csr_wdata`, the other half keeps its old value, and that cycle's increment is lost.
  - A low-half carry propagates into the high half in the same cycle.
- `CSR_COUNTERS_EN` undefined: none of the counter addresses exist; they read 0 with `csr_unimpl` = 1.

## Test plan
- Reset, then read 0x305 with RESET_VEC = 32'h8000_0003 → 32'h8000_0000; `current_mode` = 2'b11; `mstatus` reads 32'h0000_1800.
- Write 32'hFFFF_FFFF to 0x300, then read → 32'h0000_1888. Write 32'h1234_5677 to 0x341 → reads 32'h1234_5674.
- With MIE = 1 and mode = M, assert trap_valid, trap_pc = 32'h100, cause = 2:
  - after the edge: `mepc` = 32'h100, `mcause` = 2, MIE = 0, MPIE = 1, MPP = 2'b11.
  - then pulse `mret`: MIE = 1, MPP = 2'b00, mode = 2'b11.
- Same cycle `trap_valid` + `csr_we` to `mscratch` with 32'hAAAA → `mscratch` unchanged and the trap is taken.
- `CSR_COUNTERS_EN`:
  - write `mcycle` low = 32'hFFFF_FFFE and high = 0, then idle 3 cycles → high = 1 and low = 32'h0000_0001.
  - pulse `instret` 5 times → `minstret` = 5.
- Read 0x7C0 → `csr_rdata` = 0 and `csr_unimpl` = 1. Write 0x7C0 → no register changes.
